// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART FIFO bridge: RX/TX FSM state encoding and serial idle level.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_st_e;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_bridge_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and a fill count.
module uart_bridge_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          wr_data,
  input  logic                  pop,
  output logic [W-1:0]          rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic                    wr_en, rd_en;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push & ~full;
  assign rd_en   = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointers are exactly DEPTH_LOG2 wide so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// UART receiver -> FIFO -> UART transmitter bridge with RTS back-pressure.
// Define UART_FIFO_BRIDGE_CTS_EN to gate TX frame starts on the synchronised cts_n input.
module uart_fifo_bridge
  import uart_bridge_pkg::*;
#(
  parameter int CLKDIV     = 15,
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_THRESH = 2**DEPTH_LOG2 - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_pin,
  output logic                  tx_pin,
  output logic                  rts_n,
  input  logic                  cts_n,
  input  logic                  clear_err,
  output logic [DEPTH_LOG2:0]   used_slots,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLKDIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKDIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [1:0] rx_sync;
  logic       rx_s, rx_prev, cts_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= {2{LINE_IDLE}};
    else     rx_sync <= {rx_sync[0], rx_pin};
  end
  assign rx_s = rx_sync[1];

`ifdef UART_FIFO_BRIDGE_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end
  assign cts_ok = ~cts_sync[1];
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign cts_ok     = 1'b1;
`endif

  logic                 push, pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] rx_shreg, rd_data;

  uart_bridge_fifo #(.W(DATA_BITS), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (rx_shreg),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (used_slots),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- RX ----------------
  uart_st_e        rx_st, rx_nxt;
  logic [CW-1:0]   rx_cnt;
  logic [BW-1:0]   rx_bit;
  logic            rx_clr, rx_sample, ovf_set, ferr_set;

  // Start detection needs a 1->0 edge, so after a bad stop bit the line must
  // return high before another frame can arm.
  always_comb begin
    rx_nxt    = rx_st;
    rx_clr    = 1'b0;
    rx_sample = 1'b0;
    push      = 1'b0;
    ovf_set   = 1'b0;
    ferr_set  = 1'b0;
    case (rx_st)
      ST_IDLE: begin
        rx_clr = 1'b1;
        if (rx_prev && !rx_s) rx_nxt = ST_START;
      end
      ST_START: if (rx_cnt == HALF_END) begin
        rx_clr = 1'b1;
        rx_nxt = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt == BIT_END) begin
        rx_clr    = 1'b1;
        rx_sample = 1'b1;
        if (rx_bit == LAST_BIT) rx_nxt = ST_STOP;
      end
      ST_STOP: if (rx_cnt == BIT_END) begin
        rx_clr = 1'b1;
        rx_nxt = ST_IDLE;
        if (!rx_s)          ferr_set = 1'b1;
        else if (fifo_full) ovf_set  = 1'b1;
        else                push     = 1'b1;
      end
      default: rx_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st     <= ST_IDLE;
      rx_prev   <= LINE_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shreg  <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_st   <= rx_nxt;
      rx_prev <= rx_s;
      rx_cnt  <= rx_clr ? '0 : rx_cnt + 1'b1;
      if (rx_st == ST_START) rx_bit <= '0;
      else if (rx_sample)    rx_bit <= rx_bit + 1'b1;
      if (rx_sample) rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (ferr_set)       frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
    end
  end

  // ---------------- TX ----------------
  uart_st_e             tx_st, tx_nxt;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_go, tx_end, tx_clr, tx_load, tx_shift, tx_bit_inc, tx_d;

  assign tx_go  = ~fifo_empty & cts_ok;
  assign tx_end = (tx_cnt == BIT_END);

  // tx_shreg[0] always holds the next data bit to drive; it shifts as each goes out.
  always_comb begin
    tx_nxt     = tx_st;
    tx_clr     = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    tx_bit_inc = 1'b0;
    pop        = 1'b0;
    tx_d       = tx_pin;
    case (tx_st)
      ST_IDLE: begin
        tx_clr = 1'b1;
        if (tx_go) begin
          pop = 1'b1; tx_load = 1'b1; tx_d = 1'b0; tx_nxt = ST_START;
        end
      end
      ST_START: if (tx_end) begin
        tx_clr = 1'b1; tx_shift = 1'b1; tx_d = tx_shreg[0]; tx_nxt = ST_DATA;
      end
      ST_DATA: if (tx_end) begin
        tx_clr     = 1'b1;
        tx_bit_inc = 1'b1;
        if (tx_bit == LAST_BIT) begin
          tx_d = LINE_IDLE; tx_nxt = ST_STOP;
        end else begin
          tx_d = tx_shreg[0]; tx_shift = 1'b1;
        end
      end
      ST_STOP: if (tx_end) begin
        tx_clr = 1'b1;
        tx_nxt = ST_IDLE;
        if (tx_go) begin
          pop = 1'b1; tx_load = 1'b1; tx_d = 1'b0; tx_nxt = ST_START;
        end
      end
      default: tx_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st    <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_pin   <= LINE_IDLE;
      rts_n    <= 1'b1;
    end else begin
      tx_st  <= tx_nxt;
      tx_cnt <= tx_clr ? '0 : tx_cnt + 1'b1;
      tx_pin <= tx_d;
      if (tx_load) begin
        tx_shreg <= rd_data;
        tx_bit   <= '0;
      end else begin
        if (tx_shift)   tx_shreg <= {1'b0, tx_shreg[DATA_BITS-1:1]};
        if (tx_bit_inc) tx_bit   <= tx_bit + 1'b1;
      end
      rts_n <= (used_slots >= (DEPTH_LOG2+1)'(RTS_THRESH));
    end
  end

endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 Parameter CLKDIV, default 15: clk cycles per serial bit, minimum 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, range 5..9.
REQ-003 Parameter DEPTH_LOG2, default 4: FIFO depth = 2**DEPTH_LOG2 entries.
REQ-004 Parameter RTS_THRESH, default 2**DEPTH_LOG2-4: fill level at which rts_n deasserts.
REQ-005 Port clk, input, 1: single clock; all logic in this domain.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port rx_pin, input, 1: serial input, idle high, asynchronous to clk.
REQ-008 Port tx_pin, output, 1: serial output, idle high, registered.
REQ-009 Port rts_n, output, 1: flow-control request to sender, active low, registered.
REQ-010 Port cts_n, input, 1: clear-to-send from receiver, active low, asynchronous to clk.
REQ-011 Port clear_err, input, 1: single-cycle pulse that clears the sticky flags.
REQ-012 Port used_slots, output, DEPTH_LOG2+1: current FIFO fill count.
REQ-013 Port overflow, output, 1: sticky flag, byte dropped because FIFO was full.
REQ-014 Port frame_err, output, 1: sticky flag, byte dropped because stop bit was 0.

Function
REQ-015 rx_pin and cts_n SHALL each pass through a 2-flop synchroniser before use.
REQ-016 RX FSM states: IDLE, START, DATA, STOP. IDLE->START on synced rx high-to-low.
REQ-017 START re-samples at CLKDIV/2 cycles: if 0, go to DATA; if 1, return to IDLE (glitch reject).
REQ-018 DATA samples DATA_BITS bits, LSB first, one sample every CLKDIV cycles; STOP samples once more after CLKDIV cycles.
REQ-019 Stop=1 with FIFO not full: push the byte; used_slots increments on the edge after the stop sample. RX then returns to IDLE.
REQ-020 Stop=1 with FIFO full: drop the byte and set overflow. A pop in the same cycle does not rescue the byte.
REQ-021 Stop=0: drop the byte, set frame_err, and wait in IDLE for synced rx=1 before re-arming start detection.
REQ-022 FIFO read/write pointers SHALL wrap modulo 2**DEPTH_LOG2.
REQ-023 used_slots range is 0..2**DEPTH_LOG2. A simultaneous push and pop leaves it unchanged.
REQ-024 TX FSM states: IDLE, START, DATA, STOP. The FIFO is popped in the IDLE->START transition cycle, and tx_pin goes 0 on that edge.
REQ-025 IDLE->START occurs when used_slots!=0 (plus the CTS condition, REQ-033). Latency: one cycle from used_slots!=0 to tx_pin low.
REQ-026 Each TX bit lasts exactly CLKDIV cycles; data is sent LSB first; one stop bit (1). The next start bit may begin on the cycle after STOP completes.
REQ-027 rts_n is registered: 1 when used_slots>=RTS_THRESH, else 0.
REQ-028 Sticky flags: when a set event and clear_err coincide, set wins.

Reset
REQ-029 While rst is high: tx_pin=1, rts_n=1, used_slots=0, overflow=0, frame_err=0, both FSMs in IDLE, pointers 0, synchroniser flops 1.
REQ-030 Reset mid-frame aborts both FSMs immediately. No partial byte is pushed; the FIFO contents are discarded.
REQ-031 After rst falls, rts_n SHALL go 0 on the first clk edge.

Configuration
REQ-032 Macro UART_FIFO_BRIDGE_CTS_EN SHALL compile CTS flow control in or out.
REQ-033 With the macro defined, TX leaves IDLE only when synced cts_n=0. cts_n rising mid-frame SHALL NOT truncate the frame in progress.
REQ-034 Without the macro, cts_n is ignored (port still present) and its synchroniser is not instantiated.

Structure
REQ-035 Package uart_bridge_pkg SHALL hold the shared RX/TX FSM state typedef and the idle line-level constant.
REQ-036 Sub-module uart_bridge_fifo SHALL hold the synchronous FIFO (storage, pointers, count). RX and TX FSMs stay in the top module.

Verification (CLKDIV=4, DATA_BITS=8, DEPTH_LOG2=2, RTS_THRESH=3)
REQ-037 Single frame 0xA5 on rx_pin -> identical frame on tx_pin, LSB first, 4 cycles/bit; used_slots returns to 0.
REQ-038 5 back-to-back frames with cts_n=1 (macro on) -> 4 bytes stored, 5th dropped, overflow=1, rts_n=1 once used_slots reaches 3.
REQ-039 Frame 0x3C with stop bit forced 0 -> frame_err=1, used_slots stays 0; clear_err pulse -> frame_err=0.
REQ-040 rx_pin low pulse of 1 cycle -> no byte pushed, no flag set.
REQ-041 rst asserted mid-DATA of a TX frame -> tx_pin=1 and used_slots=0 immediately; no output until a new frame arrives.
REQ-042 cts_n raised mid-TX-frame (macro on) -> current frame completes; next start bit withheld until cts_n=0.
